// File: rtl/rtc_calendar_counter.sv
// System-clock RTC: prescaled seconds tick, Gregorian calendar, validated valid/ready preset.
// Define RTC_CAL_ALARM_EN to add the hh:mm:ss alarm compare and its ports.
module rtc_calendar_counter #(
  parameter int TICK_DIV = 32768,
  parameter int YEAR_W   = 12,
  parameter int RST_YEAR = 2000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              mode_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [5:0]        load_sec_i,
  input  logic [5:0]        load_min_i,
  input  logic [4:0]        load_hour_i,
  input  logic              load_pm_i,
  input  logic [2:0]        load_dow_i,
  input  logic [4:0]        load_dom_i,
  input  logic [3:0]        load_month_i,
  input  logic [YEAR_W-1:0] load_year_i,
  output logic              load_err_o,
  output logic              tick_o,
  output logic [5:0]        cur_sec_o,
  output logic [5:0]        cur_min_o,
  output logic [4:0]        cur_hour_o,
  output logic [1:0]        cur_mode_o,
  output logic [2:0]        cur_dow_o,
  output logic [4:0]        cur_dom_o,
  output logic [3:0]        cur_month_o,
  output logic [YEAR_W-1:0] cur_year_o
`ifdef RTC_CAL_ALARM_EN
  ,
  input  logic              alarm_set_i,
  input  logic [5:0]        alarm_sec_i,
  input  logic [5:0]        alarm_min_i,
  input  logic [4:0]        alarm_hour_i,
  input  logic              alarm_en_i,
  output logic              alarm_o
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    int unsigned yi;
    yi = 32'(y);
    return ((yi % 4) == 0 && (yi % 100) != 0) || (yi % 400) == 0;
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  state_t            state;
  logic [PW-1:0]     presc;
  logic [5:0]        sec_q, min_q;
  logic [4:0]        hour_q, dom_q;
  logic [2:0]        dow_q;
  logic [3:0]        month_q;
  logic [YEAR_W-1:0] year_q;

  logic [5:0]        ld_sec, ld_min;
  logic [4:0]        ld_hour, ld_dom;
  logic              ld_pm, ld_mode;
  logic [2:0]        ld_dow;
  logic [3:0]        ld_month;
  logic [YEAR_W-1:0] ld_year;

  logic [5:0]        n_sec, n_min;
  logic [4:0]        n_hour, n_dom;
  logic [2:0]        n_dow;
  logic [3:0]        n_month;
  logic [YEAR_W-1:0] n_year;
  logic [4:0]        ld_hour24;
  logic              ld_hour_ok, ld_ok, wrap, commit;

  assign wrap   = enable_i && (presc == PRESC_MAX);
  assign commit = (state == BUSY) && ld_ok;

  // Post-advance calendar: each field carries only when every lower field wraps.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    n_sec = sec_q;  n_min = min_q;  n_hour = hour_q;  n_dow = dow_q;
    n_dom = dom_q;  n_month = month_q;  n_year = year_q;
    if (sec_q != 6'd59) n_sec = sec_q + 6'd1;
    else begin
      n_sec = '0;
      if (min_q != 6'd59) n_min = min_q + 6'd1;
      else begin
        n_min = '0;
        if (hour_q != 5'd23) n_hour = hour_q + 5'd1;
        else begin
          n_hour = '0;
          n_dow  = (dow_q == 3'd7) ? 3'd1 : dow_q + 3'd1;
          if (dom_q != days_in_month(month_q, year_q)) n_dom = dom_q + 5'd1;
          else begin
            n_dom = 5'd1;
            if (month_q != 4'd12) n_month = month_q + 4'd1;
            else begin
              n_month = 4'd1;
              n_year  = year_q + 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    ld_hour24  = ld_hour;
    ld_hour_ok = (ld_hour <= 5'd23);
    if (ld_mode) begin
      ld_hour_ok = (ld_hour >= 5'd1) && (ld_hour <= 5'd12);
      if (ld_pm) ld_hour24 = (ld_hour == 5'd12) ? 5'd12 : ld_hour + 5'd12;
      else       ld_hour24 = (ld_hour == 5'd12) ? 5'd0  : ld_hour;
    end
    ld_ok = (ld_sec < 6'd60) && (ld_min < 6'd60) && ld_hour_ok && (ld_dow != 3'd0) &&
            (ld_month >= 4'd1) && (ld_month <= 4'd12) && (ld_dom >= 5'd1) &&
            (ld_dom <= days_in_month(ld_month, ld_year));
  end

  // NOTE: the preset capture registers carry no reset; BUSY is only ever entered through a capture.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && load_valid_i && load_ready_o) begin
      ld_sec   <= load_sec_i;    ld_min  <= load_min_i;  ld_hour  <= load_hour_i;
      ld_pm    <= load_pm_i;     ld_mode <= mode_i;      ld_dow   <= load_dow_i;
      ld_dom   <= load_dom_i;    ld_month <= load_month_i; ld_year <= load_year_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;  presc <= '0;
      sec_q <= '0;  min_q <= '0;  hour_q <= '0;
      dow_q <= 3'd1;  dom_q <= 5'd1;  month_q <= 4'd1;  year_q <= YEAR_W'(RST_YEAR);
      load_ready_o <= 1'b1;  load_err_o <= 1'b0;  tick_o <= 1'b0;
    end else begin
      tick_o     <= wrap && !commit;
      load_err_o <= 1'b0;
      if (commit)        presc <= '0;
      else if (enable_i) presc <= wrap ? '0 : presc + 1'b1;
      // A committing preset overrides a coincident advance.
      if (commit) begin
        sec_q <= ld_sec;  min_q <= ld_min;  hour_q <= ld_hour24;
        dow_q <= ld_dow;  dom_q <= ld_dom;  month_q <= ld_month;  year_q <= ld_year;
      end else if (wrap) begin
        sec_q <= n_sec;  min_q <= n_min;  hour_q <= n_hour;
        dow_q <= n_dow;  dom_q <= n_dom;  month_q <= n_month;  year_q <= n_year;
      end
      case (state)
        IDLE: if (load_valid_i && load_ready_o) begin
          state        <= BUSY;
          load_ready_o <= 1'b0;
        end
        BUSY: begin
          load_err_o   <= !ld_ok;
          state        <= IDLE;
          load_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 12h view is derived from the 24h state so mode_i can change at any time.
  always_comb begin
    cur_hour_o = hour_q;
    cur_mode_o = {1'b0, mode_i};
    if (mode_i) begin
      cur_mode_o[1] = (hour_q >= 5'd12);
      if (hour_q == 5'd0)      cur_hour_o = 5'd12;
      else if (hour_q > 5'd12) cur_hour_o = hour_q - 5'd12;
    end
  end

  assign cur_sec_o   = sec_q;
  assign cur_min_o   = min_q;
  assign cur_dow_o   = dow_q;
  assign cur_dom_o   = dom_q;
  assign cur_month_o = month_q;
  assign cur_year_o  = year_q;

`ifdef RTC_CAL_ALARM_EN
  logic [5:0] alarm_sec, alarm_min;
  logic [4:0] alarm_hour;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alarm_sec <= '0;  alarm_min <= '0;  alarm_hour <= '0;
      alarm_o   <= 1'b0;
    end else begin
      if (alarm_set_i) begin
        alarm_sec <= alarm_sec_i;  alarm_min <= alarm_min_i;  alarm_hour <= alarm_hour_i;
      end
      alarm_o <= wrap && !commit && alarm_en_i &&
                 (n_sec == alarm_sec) && (n_min == alarm_min) && (n_hour == alarm_hour);
    end
  end
`endif

endmodule

// File: doc/rtc_calendar_counter.md
Name: rtc_calendar_counter

Overview:
Parametrised RTC time/date counter that runs on the system clock rather than a dedicated 1 Hz clock. It has an internal prescaler that generates the seconds tick. Time is kept internally in 24h format and converted to 12h on the output, so mode changes mid-run are seamless. Preset is a valid/ready handshake with calendar validation and full Gregorian leap-year rules. It feeds the RTC register file and the display formatter.

Parameters:
TICK_DIV, 32768, system clock cycles per second tick (>=2)
YEAR_W, 12, year counter width
RST_YEAR, 2000, year loaded on reset (< 2**YEAR_W)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  1 = prescaler and calendar advance; 0 = hold all state
mode_i  in  1  output/load hour format: 1 = 12h, 0 = 24h
load_valid_i  in  1  preset request
load_ready_o  out  1  preset accepted when load_valid_i & load_ready_o
load_sec_i  in  6  preset seconds
load_min_i  in  6  preset minutes
load_hour_i  in  5  preset hour in mode_i format
load_pm_i  in  1  preset PM flag (used only when mode_i=1)
load_dow_i  in  3  preset day of week 1..7
load_dom_i  in  5  preset day of month
load_month_i  in  4  preset month 1..12
load_year_i  in  YEAR_W  preset year
load_err_o  out  1  one-cycle pulse: accepted preset rejected
tick_o  out  1  one-cycle pulse per second advance
cur_sec_o  out  6  seconds 0..59
cur_min_o  out  6  minutes 0..59
cur_hour_o  out  5  0..23 (24h) or 1..12 (12h)
cur_mode_o  out  2  bit0 = mode_i, bit1 = PM (0 in 24h)
cur_dow_o  out  3  1..7
cur_dom_o  out  5  1..31
cur_month_o  out  4  1..12
cur_year_o  out  YEAR_W  year

Behaviour:
- Reset (rst_i=1 at clk_i edge): prescaler=0; time 00:00:00; dow=1, dom=1, month=1, year=RST_YEAR; load_ready_o=1; load_err_o=0; tick_o=0. Reset overrides load and tick.
- Prescaler: increments only while enable_i=1. At count TICK_DIV-1 it wraps to 0 and the tick fires. The calendar advances in the same cycle the prescaler wraps; tick_o is registered and is high in the cycle after the advance. With enable_i=0, prescaler and calendar hold (no clearing).
- Advance chain: sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0 carries to day. Day carry: dow 7->1, else +1. dom == days_in_month -> dom=1 and the month carries. Month 12->1 carries to year. Year 2**YEAR_W-1 wraps to 0.
- days_in_month: 30 for months 4, 6, 9, 11. February is 29 when leap, else 28. All other months are 31. Leap = (y%4==0 && y%100!=0) || y%400==0.
- Output hour: 24h mode outputs the internal hour. 12h mode: internal 0 -> 12 AM; 1..11 -> AM; 12 -> 12 PM; 13..23 -> h-12 PM. Conversion is combinational from registered state; mode_i toggles take effect the same cycle.
- Load FSM states: IDLE and BUSY.
  - IDLE: load_ready_o=1. On handshake, latch all load_* and mode_i, then go to BUSY.
  - BUSY: load_ready_o=0. Validate the latched values: sec<60, min<60; hour 0..23 (24h) or 1..12 (12h); dow 1..7; month 1..12; 1<=dom<=days_in_month(month, year).
  - If valid: write the calendar (12h hour converted to 24h internal), clear the prescaler, suppress any tick that cycle.
  - If invalid: load_err_o=1 for this cycle; calendar unchanged.
  - Return to IDLE. Accept latency 1 cycle, update visible the cycle after BUSY, throughput one load per 2 cycles.
- Load while enable_i=0 is still performed; the prescaler stays cleared until enabled.
- Tick and load commit in the same cycle: the load wins, the tick is dropped, tick_o=0.
- rst_i asserted while BUSY: the load is discarded and the FSM returns to IDLE.

Optional Feature:
Macro RTC_CAL_ALARM_EN.
- Defined: adds ports alarm_set_i (1), alarm_sec_i (6), alarm_min_i (6), alarm_hour_i (5, 24h), alarm_en_i (1), and alarm_o (1).
  - alarm_set_i latches the alarm time; reset value is 00:00:00.
  - alarm_o pulses one cycle, aligned with tick_o, when alarm_en_i=1 and the post-advance time equals the alarm.
  - A load never raises alarm_o.
- Undefined: these ports and all alarm logic are absent.

Test Plan:
- TICK_DIV=4, enable_i=1 from reset -> tick_o high every 4th cycle; cur_sec_o counts 0,1,2...; enable_i=0 for 10 cycles -> no tick, values held.
- Load 2023-12-31 23:59:59, dow=7 -> one tick gives 2024-01-01 00:00:00, dow=1.
- Load 2024-02-28 23:59:59 -> tick gives 02-29. Load 2100-02-28 23:59:59 -> tick gives 03-01. Load 2000-02-28 23:59:59 -> tick gives 02-29.
- Load 2023-02-29 -> load_err_o pulses, state unchanged. Load 2023-04-31 -> load_err_o. Load hour 0 with mode_i=1 -> load_err_o.
- Internal 12:30 with mode_i=1 -> cur_hour_o=12, cur_mode_o=2'b11. Internal 00:05 -> hour 12, mode 2'b01. Toggle mode_i to 0 -> hour 0, mode 2'b00 the same cycle.
- Load commit coinciding with the prescaler wrap -> loaded value is exact, no tick_o, next tick TICK_DIV cycles later. With RTC_CAL_ALARM_EN: alarm 00:00:01 -> alarm_o with the first tick after a 00:00:00 load.
